// File: rtl/baud_rx_sampler_if.sv
// baud_rx_sampler_if: groups the receiver configuration, serial line and delivered-byte signals
interface baud_rx_sampler_if;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       rx_serial;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       rx_busy;
  modport master (
    output baud_rate, parity_type, rx_serial,
    input  data_out, data_valid, parity_error, framing_error, rx_busy
  );
  modport slave (
    input  baud_rate, parity_type, rx_serial,
    output data_out, data_valid, parity_error, framing_error, rx_busy
  );
endinterface

// File: rtl/baud_rx_sampler.sv
// baud_rx_sampler: 16x oversampling UART receiver (8 data bits, LSB first, optional parity, 1 stop)
module baud_rx_sampler #(
  parameter int DIV24  = 1302,
  parameter int DIV48  = 651,
  parameter int DIV96  = 326,
  parameter int DIV192 = 163
) (
  input  logic              clock,
  input  logic              reset_n,
  baud_rx_sampler_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t      r_state, w_next;
  logic        r_sync1, r_sync2;
  logic [1:0]  r_baud, r_par;
  logic [10:0] r_tcnt;
  logic [3:0]  r_os;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par_bit;
  logic [7:0]  r_data;
  logic        r_valid, r_perr, r_ferr;
  logic        w_rx, w_tick, w_mid, w_end, w_par_en, w_perr;
  logic [10:0] w_div;
  assign w_rx     = r_sync2;
  assign w_div    = r_baud == 2'd0 ? 11'(DIV24) : r_baud == 2'd1 ? 11'(DIV48) :
                    r_baud == 2'd2 ? 11'(DIV96) : 11'(DIV192);
  assign w_tick   = (r_state != IDLE) && (r_tcnt == w_div - 11'd1);
  assign w_mid    = w_tick && (r_os == 4'd7);
  assign w_end    = w_tick && (r_os == 4'd15);
  assign w_par_en = r_par[1] ^ r_par[0];
  assign w_perr   = w_par_en && (r_par_bit != (r_par == 2'b10 ? ^r_shift : ~^r_shift));
  assign bus.data_out      = r_data;
  assign bus.data_valid    = r_valid;
  assign bus.parity_error  = r_perr;
  assign bus.framing_error = r_ferr;
  assign bus.rx_busy       = r_state != IDLE;
  // state register; reset mid-frame simply drops back to IDLE
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  // next state: start qualified at mid start bit, every later bit sampled at os_cnt==15
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_rx ? IDLE : START;
      START:   if (w_mid) w_next = w_rx ? IDLE : DATA;
      DATA:    if (w_end && r_bit == 3'd7) w_next = w_par_en ? PARITY : STOP;
      PARITY:  if (w_end) w_next = STOP;
      STOP:    if (w_end) w_next = w_rx ? IDLE : BREAK;
      BREAK:   if (w_rx) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // synchroniser, tick/oversample counters, shift register and delivered-byte registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_baud    <= 2'd0;
      r_par     <= 2'd0;
      r_tcnt    <= 11'd0;
      r_os      <= 4'd0;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_par_bit <= 1'b0;
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1 <= bus.rx_serial;
      r_sync2 <= r_sync1;
      r_valid <= (r_state == STOP) && w_end;
      if (r_state == IDLE) begin
        r_tcnt <= 11'd0;
        r_os   <= 4'd0;
        if (!w_rx) begin
          r_baud <= bus.baud_rate;
          r_par  <= bus.parity_type;
        end
      end else begin
        r_tcnt <= w_tick ? 11'd0 : r_tcnt + 11'd1;
        if (w_tick) r_os <= r_os + 4'd1;
      end
      if (r_state == START && w_mid) begin
        r_os  <= 4'd0;
        r_bit <= 3'd0;
      end
      if (r_state == DATA && w_end) begin
        r_shift <= {w_rx, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (r_state == PARITY && w_end) r_par_bit <= w_rx;
      if (r_state == STOP && w_end) begin
        r_data <= r_shift;
        r_perr <= w_perr;
        r_ferr <= ~w_rx;
      end
    end
  end
endmodule
